// File: rtl/pcm_feeder_if.sv
// -----------------------------------------------------------------------------
// pcm_feeder_if
//
// Simple register-bus bundle used between a CPU-side master and pcm_feeder.
//
// Signals:
//   valid  request, held high by the master until ready
//   addr   byte offset (pcm_feeder decodes [3:2])
//   wstrb  byte write strobes; all-zero means read
//   wdata  write data, lane k = wdata[8k+7:8k]
//   rdata  read data, meaningful while ready = 1
//   ready  one-cycle completion pulse from the slave
//
// Modports:
//   master  drives the request, receives rdata/ready
//   slave   receives the request, drives rdata/ready
// -----------------------------------------------------------------------------
interface pcm_feeder_if;
    logic        valid;
    logic [3:0]  addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output valid,
        output addr,
        output wstrb,
        output wdata,
        input  rdata,
        input  ready
    );

    modport slave (
        input  valid,
        input  addr,
        input  wstrb,
        input  wdata,
        output rdata,
        output ready
    );
endinterface

// File: rtl/pcm_feeder.sv
// -----------------------------------------------------------------------------
// pcm_feeder
//
// Bus-side audio front end for the PWM audio DAC. A 32-bit DATA write carries
// up to four packed 8-bit PCM samples (one per enabled byte lane). Each sample
// is optionally converted from two's complement to offset binary, scaled by
// the volume setting and pushed, one per cycle, into the DAC sample FIFO. The
// FIFO full flag is honoured so that no sample is lost or duplicated.
//
// Register map (addr[3:2]):
//   0 DATA    write: latch samples, lanes selected by wstrb; reads 0
//   1 CTRL    bit0 signed_mode, bits[15:8] vol; byte-writable
//   2 STATUS  bit0 busy, bit1 fifo_full_i, bits[7:4] pending lanes (RO)
//   3 -       reserved, reads 0, writes ignored
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   bus          register bus (slave side of pcm_feeder_if)
//   pcm_o        processed sample (offset binary) to the DAC FIFO din
//   we_o         push strobe to the DAC FIFO
//   fifo_full_i  DAC FIFO full flag
//
// Parameters:
//   VOL_RESET     reset value of CTRL.vol (8'hFF = unity gain)
//   SIGNED_RESET  reset value of CTRL.signed_mode
// -----------------------------------------------------------------------------
module pcm_feeder #(
    parameter logic [7:0] VOL_RESET    = 8'hFF,
    parameter logic       SIGNED_RESET = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    pcm_feeder_if.slave  bus,
    output logic [7:0]   pcm_o,
    output logic         we_o,
    input  logic         fifo_full_i
);

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t      state_reg;
    logic [31:0] data_reg;          // latched sample word
    logic [3:0]  pending_reg;       // lanes not yet moved into the stage
    logic        stage_valid_reg;   // output stage holds an unsent sample
    logic [7:0]  pcm_reg;           // output stage sample
    logic        signed_reg;        // CTRL.signed_mode
    logic [7:0]  vol_reg;           // CTRL.vol
    logic        ready_reg;
    logic [31:0] rdata_reg;

    // -------------------------------------------------------------------------
    // Bus decode
    // -------------------------------------------------------------------------
    logic [1:0]  reg_sel;
    logic        is_write;
    logic        req_new;
    logic        data_wr;
    logic        stall;
    logic        accept;
    logic [31:0] read_val;
    logic        unused_addr_bits;

    assign reg_sel          = bus.addr[3:2];
    assign unused_addr_bits = ^bus.addr[1:0];
    assign is_write         = |bus.wstrb;

    // A request still held in the cycle its ready pulse is shown is the same
    // transaction, so it must not be taken a second time.
    assign req_new = bus.valid & ~ready_reg;
    assign data_wr = req_new & is_write & (reg_sel == REG_DATA);

    // Only a DATA write waits for the current burst; everything else completes
    // right away, even while samples are streaming out.
    assign stall  = data_wr & (state_reg == ST_SEND);
    assign accept = req_new & ~stall;

    always_comb begin
        read_val = '0;
        case (reg_sel)
            REG_CTRL:   read_val = {16'h0000, vol_reg, 7'b0000000, signed_reg};
            REG_STATUS: read_val = {24'h000000, pending_reg, 2'b00, fifo_full_i,
                                    (state_reg == ST_SEND)};
            default:    read_val = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Sample processing, one instance per byte lane
    //   s = signed_mode ? lane ^ 8'h80 : lane
    //   c = s - 128                        (signed)
    //   p = (c * (vol + 1)) >>> 8          (arithmetic)
    //   out = p + 128, truncated to 8 bits
    // With vol = 255 the gain is exactly 256/256, so samples pass unchanged.
    // -------------------------------------------------------------------------
    logic [31:0] proc_bus;
    logic [9:0]  gain_u;

    // vol + 1 needs 9 bits (up to 256); one more keeps it positive as signed.
    assign gain_u = {2'b00, vol_reg} + 10'd1;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0]         lane_s;
            logic signed [9:0]  lane_c;
            logic signed [9:0]  lane_g;
            logic signed [19:0] lane_prod;
            logic signed [19:0] lane_shift;

            assign lane_s     = data_reg[8*gi +: 8] ^ {signed_reg, 7'b0000000};
            assign lane_c     = $signed({2'b00, lane_s}) - 10'sd128;
            assign lane_g     = $signed(gain_u);
            assign lane_prod  = 20'(lane_c) * 20'(lane_g);
            assign lane_shift = lane_prod >>> 8;
            // Adding 128 to an 8-bit two's complement value is a top-bit flip.
            assign proc_bus[8*gi +: 8] = lane_shift[7:0] ^ 8'h80;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Lane selection: lowest set pending bit
    // -------------------------------------------------------------------------
    logic [1:0] sel_lane;
    logic [3:0] lowest_bit;

    always_comb begin
        sel_lane = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending_reg[i]) begin
                sel_lane = 2'(i);
            end
        end
    end

    assign lowest_bit = pending_reg & (~pending_reg + 4'd1);

    // -------------------------------------------------------------------------
    // Output stage control
    // -------------------------------------------------------------------------
    logic stage_load;
    logic drain_done;

    assign we_o       = stage_valid_reg & ~fifo_full_i;
    assign stage_load = we_o | ~stage_valid_reg;

    // Leave SEND in the same cycle the last sample leaves the stage, so busy
    // drops on the cycle after the final push.
    assign drain_done = (pending_reg == 4'd0) & (~stage_valid_reg | we_o);

    assign pcm_o     = pcm_reg;
    assign bus.ready = ready_reg;
    assign bus.rdata = rdata_reg;

    // -------------------------------------------------------------------------
    // Sequential logic: FSM, registers, output stage, bus response
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            data_reg        <= '0;
            pending_reg     <= '0;
            stage_valid_reg <= 1'b0;
            pcm_reg         <= '0;
            signed_reg      <= SIGNED_RESET;
            vol_reg         <= VOL_RESET;
            ready_reg       <= 1'b0;
            rdata_reg       <= '0;
        end else begin
            ready_reg <= accept;
            rdata_reg <= (accept && !is_write) ? read_val : 32'h0000_0000;

            // CTRL byte writes; bytes 2 and 3 hold no fields.
            if (accept && is_write && (reg_sel == REG_CTRL)) begin
                if (bus.wstrb[0]) begin
                    signed_reg <= bus.wdata[0];
                end
                if (bus.wstrb[1]) begin
                    vol_reg <= bus.wdata[15:8];
                end
            end

            // The stage refills whenever it is empty or being emptied this
            // cycle; a sample that stays put keeps its processed value even if
            // CTRL changes underneath it.
            if (stage_load) begin
                if (pending_reg != 4'd0) begin
                    pcm_reg         <= proc_bus[8*sel_lane +: 8];
                    stage_valid_reg <= 1'b1;
                end else begin
                    stage_valid_reg <= 1'b0;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (accept && data_wr) begin
                        data_reg    <= bus.wdata;
                        pending_reg <= bus.wstrb;
                        state_reg   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (stage_load && (pending_reg != 4'd0)) begin
                        pending_reg <= pending_reg & ~lowest_bit;
                    end
                    if (drain_done) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_feeder.sv
// -----------------------------------------------------------------------------
// tb_pcm_feeder
//
// Directed bench for pcm_feeder. Stimulus tasks push the expected FIFO pushes
// (value and, where it matters, cycle) and the expected read data into queues;
// a monitor process compares them against we_o/pcm_o and ready/rdata.
// -----------------------------------------------------------------------------
module tb_pcm_feeder;

    localparam logic [3:0] A_DATA   = 4'h0;
    localparam logic [3:0] A_CTRL   = 4'h4;
    localparam logic [3:0] A_STATUS = 4'h8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fifo_full = 1'b0;
    logic [7:0] pcm;
    logic       we;

    pcm_feeder_if bus ();

    pcm_feeder #(
        .VOL_RESET   (8'hFF),
        .SIGNED_RESET(1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .pcm_o      (pcm),
        .we_o       (we),
        .fifo_full_i(fifo_full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] d;
        int         c;      // required cycle, -1 when only order matters
    } push_t;

    typedef struct {
        logic        chk;   // 0 for writes: rdata not checked
        logic [31:0] v;
    } rd_t;

    push_t push_q[$];
    rd_t   rd_q[$];
    push_t pe;
    rd_t   re;

    // ------------------------------------------------------------------ monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (we) begin
                total++;
                if (push_q.size() == 0) begin
                    bad++;
                    $display("FAIL push_extra: got pcm=%02h at cyc %0d, required no push", pcm, cyc);
                end else begin
                    pe = push_q.pop_front();
                    if (pcm !== pe.d || (pe.c >= 0 && cyc != pe.c)) begin
                        bad++;
                        $display("FAIL push: got pcm=%02h at cyc %0d, required %02h at cyc %0d",
                                 pcm, cyc, pe.d, pe.c);
                    end else begin
                        $display("push ok: pcm=%02h cyc=%0d", pcm, cyc);
                    end
                end
            end
            if (bus.ready) begin
                total++;
                if (rd_q.size() == 0) begin
                    bad++;
                    $display("FAIL ready_extra: ready at cyc %0d with no outstanding access", cyc);
                end else begin
                    re = rd_q.pop_front();
                    if (re.chk && bus.rdata !== re.v) begin
                        bad++;
                        $display("FAIL rdata: got %08h at cyc %0d, required %08h", bus.rdata, cyc, re.v);
                    end else begin
                        $display("access ok: rdata=%08h cyc=%0d", bus.rdata, cyc);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------ helpers
    task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", nm, got, exp);
        end else begin
            $display("check ok: %s = %0h", nm, got);
        end
    endtask

    function automatic void exp_push(input logic [7:0] d, input int c);
        push_t p;
        p.d = d;
        p.c = c;
        push_q.push_back(p);
    endfunction

    // Entered just after a rising edge; returns just after a rising edge.
    task automatic do_access(input logic [3:0] a, input logic [3:0] s, input logic [31:0] d,
                             input logic chk, input logic [31:0] exp, output int acc);
        rd_t e;
        e.chk = chk;
        e.v   = exp;
        rd_q.push_back(e);
        bus.addr  = a;
        bus.wstrb = s;
        bus.wdata = d;
        bus.valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                acc = cyc - 1;
                break;
            end
        end
        if (acc < 0) begin
            total++;
            bad++;
            $display("FAIL access_timeout: addr=%0h got no ready in 200 cycles, required ready", a);
            if (rd_q.size() > 0) void'(rd_q.pop_back());
        end
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        bus.wstrb = 4'h0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp);
        int iss;
        int acc;
        iss = cyc;
        do_access(a, 4'h0, 32'h0, 1'b1, exp, acc);
        check32("read_accept_cycle", 32'(acc), 32'(iss));
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] s, input logic [31:0] d, output int acc);
        do_access(a, s, d, 1'b0, 32'h0, acc);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (push_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (push_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d pushes missing after 100 cycles, required 0", push_q.size());
            push_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------ watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------ stimulus
    initial begin
        int k;
        int acc;
        int acc2;

        bus.valid = 1'b0;
        bus.addr  = 4'h0;
        bus.wstrb = 4'h0;
        bus.wdata = 32'h0;

        // Reset state
        @(negedge clk);
        check32("reset_we", 32'(we), 32'h0);
        check32("reset_ready", 32'(bus.ready), 32'h0);
        check32("reset_rdata", bus.rdata, 32'h0);
        check32("reset_pcm", 32'(pcm), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        rd(A_CTRL, 32'h0000_FF00);
        rd(A_STATUS, 32'h0000_0000);

        // Unity gain, unsigned, four lanes back to back at N+2..N+5
        k = cyc;
        exp_push(8'h40, k + 2);
        exp_push(8'h00, k + 3);
        exp_push(8'hFF, k + 4);
        exp_push(8'h80, k + 5);
        wr(A_DATA, 4'hF, 32'h80FF_0040, acc);
        check32("data_accept_cycle", 32'(acc), 32'(k));
        // At N+2 lane 0 is staged: pending=1110, busy=1
        rd(A_STATUS, 32'h0000_00E1);
        wait_drain();

        // Signed mode, vol 127: lane0 = -128 -> 8'h40; busy low at N+3
        wr(A_CTRL, 4'h3, 32'h0000_7F01, acc);
        rd(A_CTRL, 32'h0000_7F01);
        k = cyc;
        exp_push(8'h40, k + 2);
        wr(A_DATA, 4'h1, 32'h0000_0080, acc);
        @(posedge clk);
        #1;
        rd(A_STATUS, 32'h0000_0000);
        wait_drain();

        // vol 0, unsigned: c<0 -> 7F, c>=0 -> 80
        wr(A_CTRL, 4'h3, 32'h0000_0000, acc);
        k = cyc;
        exp_push(8'h7F, k + 2);
        exp_push(8'h7F, k + 3);
        exp_push(8'h80, k + 4);
        exp_push(8'h80, k + 5);
        wr(A_DATA, 4'hF, 32'hFF80_7F00, acc);
        wait_drain();

        // vol 127, unsigned, sparse strobes (lane 2 skipped)
        wr(A_CTRL, 4'h3, 32'h0000_7F00, acc);
        k = cyc;
        exp_push(8'h7F, k + 2);
        exp_push(8'hA0, k + 3);
        exp_push(8'h80, k + 4);
        wr(A_DATA, 4'hB, 32'h8122_C07F, acc);
        wait_drain();

        // DATA write with no strobes: read-like, no pushes
        rd(A_DATA, 32'h0000_0000);
        rd(A_STATUS, 32'h0000_0000);

        // FIFO full from N+3 for 10 cycles
        wr(A_CTRL, 4'h3, 32'h0000_FF00, acc);
        k = cyc;
        exp_push(8'h11, k + 2);
        exp_push(8'h22, k + 13);
        exp_push(8'h33, k + 14);
        exp_push(8'h44, k + 15);
        wr(A_DATA, 4'hF, 32'h4433_2211, acc);
        fork
            begin
                @(posedge clk);
                #1;
                fifo_full = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                fifo_full = 1'b0;
            end
            begin
                @(posedge clk);
                #2;
                // pending=1100, fifo_full=1, busy=1
                rd(A_STATUS, 32'h0000_00C3);
            end
        join
        wait_drain();

        // Back-to-back DATA writes: second stalled until N+6
        k = cyc;
        exp_push(8'h01, k + 2);
        exp_push(8'h02, k + 3);
        exp_push(8'h03, k + 4);
        exp_push(8'h04, k + 5);
        exp_push(8'h05, k + 8);
        exp_push(8'h06, k + 9);
        exp_push(8'h07, k + 10);
        exp_push(8'h08, k + 11);
        wr(A_DATA, 4'hF, 32'h0403_0201, acc);
        wr(A_DATA, 4'hF, 32'h0807_0605, acc2);
        check32("burst1_accept_cycle", 32'(acc), 32'(k));
        check32("burst2_accept_cycle", 32'(acc2), 32'(k + 6));
        wait_drain();

        // Reset after two pushes (signed, unity: out = lane ^ 80)
        wr(A_CTRL, 4'h3, 32'h0000_FF01, acc);
        k = cyc;
        exp_push(8'h2A, k + 2);
        exp_push(8'h3B, k + 3);
        wr(A_DATA, 4'hF, 32'hDDCC_BBAA, acc);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check32("reset_mid_we", 32'(we), 32'h0);
        check32("reset_mid_pcm", 32'(pcm), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check32("pushes_left_after_reset", 32'(push_q.size()), 32'h0);
        rd(A_CTRL, 32'h0000_FF00);
        rd(A_STATUS, 32'h0000_0000);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcm_feeder.md
# pcm_feeder

Bus-side audio front end that sits directly upstream of the PWM audio DAC. Accepts 32-bit CPU writes carrying up to four packed 8-bit PCM samples, applies signed/unsigned conversion and a volume scale, and serialises the samples one per cycle into the DAC's sample FIFO. Honours the FIFO's full flag so that no sample is ever lost or duplicated.

## Interface
- VOL_RESET, 8'hFF, reset value of the volume field (unity gain).
- SIGNED_RESET, 1'b0, reset value of the signed-mode bit.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- valid  in  1  bus request; held high until `ready`
- addr  in  4  byte offset; only [3:2] decoded: 0 DATA, 1 CTRL, 2 STATUS, 3 reserved
- wstrb  in  4  byte write strobes; 0 means read
- wdata  in  32  write data; lane k = wdata[8k+7:8k]
- rdata  out  32  read data, valid while `ready`=1
- ready  out  1  one-cycle registered completion pulse
- pcm_o  out  8  processed sample (offset-binary) to the DAC FIFO `din`
- we_o  out  1  push strobe to the DAC FIFO
- fifo_full_i  in  1  DAC FIFO full flag

## Operation
- Registers:
  - CTRL: bit0 `signed_mode`, bits[15:8] `vol`; all other bits read 0. Written bytewise per `wstrb`.
  - STATUS (read-only): bit0 `busy`, bit1 `fifo_full_i`, bits[7:4] `pending` lane mask; all other bits read 0.
  - DATA and reserved offsets read 0.
  - Writes to STATUS and reserved are accepted and ignored.
- FSM states:
  - IDLE:
    - A DATA write latches `wdata` and takes `pending` = `wstrb`, then moves to SEND.
    - Any other access completes immediately.
  - SEND:
    - CTRL/STATUS/reserved accesses complete normally.
    - A DATA write is stalled: `ready` stays 0 until the FSM returns to IDLE, after which the write is accepted as from IDLE.
    - Returns to IDLE when `pending`==0 and `stage_valid`==0.
- Output stage (one-entry register: `pcm_o`, `stage_valid`):
  - `we_o` = `stage_valid` & ~`fifo_full_i` (combinational; the only combinational output path).
  - When `we_o`=1 or `stage_valid`=0, the stage loads the processed sample of the lowest set `pending` lane and clears that bit. If `pending`==0, `stage_valid` clears.
- Sample processing, applied at stage load using the CTRL value current in that cycle:
  - s = signed_mode ? lane ^ 8'h80 : lane.
  - c = s − 128 (9-bit signed).
  - p = (c × (vol+1)) >>> 8 (arithmetic shift).
  - pcm_o = p + 128, truncated to 8 bits.
  - vol=255 is exact identity. vol=0 yields 127 for c<0 and 128 for c≥0.
- `busy` = state==SEND.
- A DATA write with `wstrb`=0 is treated as a read (returns 0) and causes no pushes.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state IDLE, `pending`=0, `stage_valid`=0, `we_o`=0, `pcm_o`=0, `ready`=0, `rdata`=0.
  - CTRL = {VOL_RESET, SIGNED_RESET}.
  - Reset mid-burst discards all unsent samples.
- Access accepted in cycle N: `ready`=1 in cycle N+1 only. `valid` must be deasserted or a new request presented in N+2. A request still high in N+1 is not re-accepted.
- DATA accept in cycle N with all four strobes and the FIFO never full:
  - stage loads at the end of N+1.
  - `we_o`=1 in cycles N+2, N+3, N+4, N+5 carrying lanes 0, 1, 2, 3.
  - `busy` high N+1..N+5, low from N+6.
- `fifo_full_i` high: `we_o`=0 and `pcm_o` is held. Pushing resumes in the same cycle `fifo_full_i` falls. No lane is skipped or repeated.
- A CTRL write completing in cycle M affects samples loaded into the stage from cycle M+1 onward. A sample already staged is not re-processed.
- A back-to-back stalled DATA write is accepted in the first IDLE cycle, so its first push follows the last push of the previous burst by 3 cycles.

## Test plan
- Reset, then read CTRL -> rdata=32'h0000FF00 with `ready` exactly one cycle later. Read STATUS -> 0.
- DATA write 32'h80FF0040, wstrb 4'hF, unsigned, vol 255 -> pushes 8'h40, 8'h00, 8'hFF, 8'h80 in consecutive cycles N+2..N+5.
- Signed mode, vol 127, DATA 32'h00000080 (lane0 = −128), wstrb 4'h1 -> one push of 8'h40. STATUS.busy falls at N+3.
- Hold `fifo_full_i` high for 10 cycles starting at N+3 during a 4-lane write -> lane 0 pushed at N+2, lanes 1..3 pushed on the 3 cycles following the release. Exactly 4 pushes total.
- Second DATA write issued while busy -> `ready` is withheld until the first burst drains; all 8 samples arrive in order.
- Assert `reset` mid-burst after 2 pushes -> `we_o` drops immediately, no further pushes, CTRL returns to reset values.
